wb_write_arbiter: RTL and testbench

- Drives the single write port of the general-purpose register file (we3/wa3/wd3).
- Merges two write sources:
  - the in-order pipeline writeback slot;
  - results from long-latency units (divider, uncached loads), delivered through a valid/ready handshake and buffered in a small FIFO.
- Keeps a 32-entry pending scoreboard so decode can stall on registers that are still awaiting a long-latency result.
- Sits between the WB stage / long-latency units and the register file, with no added write latency.

---
 rtl/wb_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges the pipeline WB write with buffered
// long-latency results and tracks which registers still await a long result.
module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               pipe_we,
  input  logic [4:0]               pipe_wa,
  input  logic [31:0]              pipe_wd,
  output logic                     pipe_stall,
  input  logic                     lo_issue,
  input  logic [4:0]               lo_issue_wa,
  input  logic                     lo_valid,
  output logic                     lo_ready,
  input  logic [4:0]               lo_wa,
  input  logic [31:0]              lo_wd,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [3:0]               we3,
  output logic [4:0]               wa3,
  output logic [31:0]              wd3,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Long-op handshake: a result transfers on a cycle where lo_valid && lo_ready;
  // lo_ready depends only on FIFO space and this cycle's pop, never on lo_valid.

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DRAIN,
    SEL_PIPE,
    SEL_HEAD,
    SEL_BYPASS
  } sel_t;

  sel_t          sel;
  logic [4:0]    fifo_wa [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve;
  logic [31:0]   pending;
  logic [31:0]   pending_next;

  logic pipe_req;
  logic full;
  logic empty;
  logic forced;
  logic pop;
  logic bypass;
  logic push;
  logic [4:0]  head_wa;
  logic [31:0] head_wd;

  assign pipe_req = (pipe_we != 4'b0000) && (pipe_wa != 5'd0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign forced   = full && (starve == SW'(STARVE_LIMIT));
  assign head_wa  = fifo_wa[rd_ptr];
  assign head_wd  = fifo_wd[rd_ptr];

  always_comb begin
    sel = SEL_NONE;
    if (rst)                                 sel = SEL_NONE;
    else if (forced)                         sel = SEL_DRAIN;
    else if (pipe_req)                       sel = SEL_PIPE;
    else if (!empty)                         sel = SEL_HEAD;
    else if (lo_valid && (lo_wa != 5'd0))    sel = SEL_BYPASS;
  end

  assign pop        = (sel == SEL_DRAIN) || (sel == SEL_HEAD);
  assign bypass     = (sel == SEL_BYPASS);
  assign lo_ready   = !rst && (!full || pop);
  // r0 results complete the handshake but are simply dropped.
  assign push       = lo_valid && lo_ready && !bypass && (lo_wa != 5'd0);
  assign pipe_stall = (sel == SEL_DRAIN) && pipe_req;
  assign fifo_count = count;

  always_comb begin
    we3 = 4'b0000;
    wa3 = 5'd0;
    wd3 = 32'd0;
    case (sel)
      SEL_DRAIN, SEL_HEAD: begin
        we3 = 4'b1111;
        wa3 = head_wa;
        wd3 = head_wd;
      end
      SEL_PIPE: begin
        we3 = pipe_we;
        wa3 = pipe_wa;
        wd3 = pipe_wd;
      end
      SEL_BYPASS: begin
        we3 = 4'b1111;
        wa3 = lo_wa;
        wd3 = lo_wd;
      end
      default: begin
        we3 = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= lo_wa;
      fifo_wd[wr_ptr] <= lo_wd;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (pop || !full) begin
      starve <= '0;
    end else if ((sel == SEL_PIPE) && (starve != SW'(STARVE_LIMIT))) begin
      starve <= starve + SW'(1);
    end
  end

  // Clears are applied before the set so an issue to the same register wins.
  always_comb begin
    pending_next = pending;
    if (pop)    pending_next[head_wa] = 1'b0;
    if (bypass) pending_next[lo_wa]   = 1'b0;
    if (lo_issue && (lo_issue_wa != 5'd0)) pending_next[lo_issue_wa] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  assign busy1 = !rst && pending[ra1];
  assign busy2 = !rst && pending[ra2];

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected port writes are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        lo_issue;
  logic [4:0]  lo_issue_wa;
  logic        lo_valid;
  logic        lo_ready;
  logic [4:0]  lo_wa;
  logic [31:0] lo_wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        busy1;
  logic        busy2;
  logic [3:0]  we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [1:0]  fifo_count;

  logic [40:0] exp_q[$];
  int checks;
  int errors;

  wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .lo_issue(lo_issue), .lo_issue_wa(lo_issue_wa),
    .lo_valid(lo_valid), .lo_ready(lo_ready), .lo_wa(lo_wa), .lo_wd(lo_wd),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .fifo_count(fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    if (we3 != 4'b0000) begin
      logic [40:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL port_write: unexpected we=%h wa=%0d wd=%h, none expected", we3, wa3, wd3);
      end else begin
        e = exp_q.pop_front();
        if ({we3, wa3, wd3} !== e) begin
          errors++;
          $display("FAIL port_write: got we=%h wa=%0d wd=%h, expected we=%h wa=%0d wd=%h",
                   we3, wa3, wd3, e[40:37], e[36:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pipe(input logic [3:0] we, input logic [4:0] wa, input logic [31:0] wd);
    pipe_we = we;
    pipe_wa = wa;
    pipe_wd = wd;
  endtask

  task automatic set_lo(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    lo_valid = v;
    lo_wa    = wa;
    lo_wd    = wd;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] wa);
    lo_issue    = v;
    lo_issue_wa = wa;
  endtask

  task automatic expect_wr(input logic [3:0] we, input logic [4:0] wa, input logic [31:0] wd);
    exp_q.push_back({we, wa, wd});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_pipe(4'h0, 5'd0, 32'd0);
    set_issue(1'b0, 5'd0);
    set_lo(1'b1, 5'd3, 32'h33);
    ra1 = 5'd8;
    ra2 = 5'd9;

    // reset with a pending long result
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_lo_ready", lo_ready, 0);
      chk("rst_we3", we3, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_stall", pipe_stall, 0);
      tick();
    end
    rst = 1'b0;
    set_lo(1'b0, 5'd0, 32'd0);
    sample();
    chk("idle_busy1", busy1, 0);
    chk("idle_busy2", busy2, 0);
    chk("idle_count", fifo_count, 0);
    tick();

    // pipeline-only writes
    set_pipe(4'hF, 5'd5, 32'hDEADBEEF);
    expect_wr(4'hF, 5'd5, 32'hDEADBEEF);
    sample();
    chk("pipe_stall_free", pipe_stall, 0);
    tick();
    set_pipe(4'b0011, 5'd6, 32'h12345678);
    expect_wr(4'b0011, 5'd6, 32'h12345678);
    sample();
    tick();
    set_pipe(4'hF, 5'd0, 32'hDEADBEEF);
    sample();
    chk("pipe_r0_we3", we3, 0);
    tick();
    set_pipe(4'h0, 5'd0, 32'd0);

    // bypass plus scoreboard
    ra1 = 5'd8;
    set_issue(1'b1, 5'd8);
    sample();
    chk("bp_busy_before", busy1, 0);
    tick();
    set_issue(1'b0, 5'd0);
    sample();
    chk("bp_busy_wait", busy1, 1);
    tick();
    set_lo(1'b1, 5'd8, 32'd7);
    expect_wr(4'hF, 5'd8, 32'd7);
    sample();
    chk("bp_busy_commit", busy1, 1);
    chk("bp_lo_ready", lo_ready, 1);
    tick();
    set_lo(1'b0, 5'd0, 32'd0);
    sample();
    chk("bp_busy_after", busy1, 0);
    chk("bp_count", fifo_count, 0);
    tick();

    // contention: results for 9 and 10 queue behind the pipeline
    set_pipe(4'hF, 5'd1, 32'h1000);
    expect_wr(4'hF, 5'd1, 32'h1000);
    set_lo(1'b1, 5'd9, 32'h99);
    sample();
    chk("ct0_lo_ready", lo_ready, 1);
    chk("ct0_count", fifo_count, 0);
    tick();
    set_pipe(4'hF, 5'd1, 32'h1001);
    expect_wr(4'hF, 5'd1, 32'h1001);
    set_lo(1'b1, 5'd10, 32'hAA);
    sample();
    chk("ct1_lo_ready", lo_ready, 1);
    chk("ct1_count", fifo_count, 1);
    tick();
    set_lo(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_pipe(4'hF, 5'd1, 32'h1002 + i);
      expect_wr(4'hF, 5'd1, 32'h1002 + i);
      sample();
      chk("ct_blocked_count", fifo_count, 2);
      chk("ct_blocked_ready", lo_ready, 0);
      chk("ct_blocked_stall", pipe_stall, 0);
      tick();
    end
    // forced drain of reg 9 with a simultaneous push of reg 11
    set_pipe(4'hF, 5'd1, 32'h1006);
    expect_wr(4'hF, 5'd9, 32'h99);
    set_lo(1'b1, 5'd11, 32'hBB);
    sample();
    chk("drain1_stall", pipe_stall, 1);
    chk("drain1_lo_ready", lo_ready, 1);
    chk("drain1_count", fifo_count, 2);
    tick();
    set_lo(1'b0, 5'd0, 32'd0);
    expect_wr(4'hF, 5'd1, 32'h1006);
    sample();
    chk("repres_count", fifo_count, 2);
    chk("repres_stall", pipe_stall, 0);
    chk("repres_ready", lo_ready, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_pipe(4'hF, 5'd1, 32'h1007 + i);
      expect_wr(4'hF, 5'd1, 32'h1007 + i);
      sample();
      chk("ct2_blocked_stall", pipe_stall, 0);
      tick();
    end
    set_pipe(4'hF, 5'd1, 32'h100A);
    expect_wr(4'hF, 5'd10, 32'hAA);
    sample();
    chk("drain2_stall", pipe_stall, 1);
    tick();
    set_pipe(4'h0, 5'd0, 32'd0);
    expect_wr(4'hF, 5'd11, 32'hBB);
    sample();
    chk("head_count", fifo_count, 1);
    chk("head_stall", pipe_stall, 0);
    tick();
    sample();
    chk("drained_count", fifo_count, 0);
    chk("drained_we3", we3, 0);
    tick();

    // set/clear race on reg 12
    ra2 = 5'd12;
    set_issue(1'b1, 5'd12);
    tick();
    set_lo(1'b1, 5'd12, 32'hC);
    expect_wr(4'hF, 5'd12, 32'hC);
    sample();
    chk("race_busy_commit", busy2, 1);
    tick();
    set_issue(1'b0, 5'd0);
    set_lo(1'b0, 5'd0, 32'd0);
    sample();
    chk("race_busy_after", busy2, 1);
    tick();
    set_lo(1'b1, 5'd12, 32'hD);
    expect_wr(4'hF, 5'd12, 32'hD);
    tick();
    set_lo(1'b0, 5'd0, 32'd0);
    sample();
    chk("race_busy_clear", busy2, 0);
    tick();

    // long result and issue targeting r0
    ra1 = 5'd0;
    set_issue(1'b1, 5'd0);
    set_lo(1'b1, 5'd0, 32'h5);
    sample();
    chk("r0_lo_ready", lo_ready, 1);
    chk("r0_we3", we3, 0);
    tick();
    set_issue(1'b0, 5'd0);
    set_lo(1'b0, 5'd0, 32'd0);
    sample();
    chk("r0_count", fifo_count, 0);
    chk("r0_busy", busy1, 0);
    tick();

    // reset while the FIFO holds results
    ra1 = 5'd13;
    set_pipe(4'hF, 5'd2, 32'h2000);
    expect_wr(4'hF, 5'd2, 32'h2000);
    set_issue(1'b1, 5'd13);
    set_lo(1'b1, 5'd13, 32'hD13);
    tick();
    set_issue(1'b0, 5'd0);
    set_pipe(4'hF, 5'd2, 32'h2001);
    expect_wr(4'hF, 5'd2, 32'h2001);
    set_lo(1'b1, 5'd14, 32'hD14);
    tick();
    set_pipe(4'hF, 5'd2, 32'h2002);
    expect_wr(4'hF, 5'd2, 32'h2002);
    set_lo(1'b0, 5'd0, 32'd0);
    sample();
    chk("mid_count", fifo_count, 2);
    chk("mid_busy", busy1, 1);
    tick();
    rst = 1'b1;
    set_pipe(4'hF, 5'd2, 32'h2003);
    sample();
    chk("mid_rst_we3", we3, 0);
    chk("mid_rst_ready", lo_ready, 0);
    chk("mid_rst_busy", busy1, 0);
    tick();
    rst = 1'b0;
    set_pipe(4'h0, 5'd0, 32'd0);
    sample();
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_we3", we3, 0);
    chk("post_rst_busy", busy1, 0);
    tick();
    sample();
    chk("post_rst_idle_we3", we3, 0);
    tick();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
